// File: rtl/systolic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_pkg
// Shared definitions for the systolic array sequencer: FSM state encodings and
// default array/length parameters.
// Optional feature macro used by systolic_ctrl: SYS_CTRL_ABORT_EN.
// -----------------------------------------------------------------------------
package systolic_ctrl_pkg;

    localparam int DEF_N   = 4;
    localparam int DEF_K_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_ctrl_feed_skew.sv
// -----------------------------------------------------------------------------
// sys_feed_skew
// Combinational decode of the skewed per-row operand feed enables.
// Row i is fed while run_cnt is in [i, i + k_reg), and only while the
// sequencer is in its RUN state.
// Ports:
//   run      in  1      sequencer is in RUN
//   run_cnt  in  K_W+1  cycle index inside RUN
//   k_reg    in  K_W    latched inner dimension
//   feed_en  out N      per-row operand valid (bit i = row i)
// -----------------------------------------------------------------------------
module sys_feed_skew #(
    parameter int N   = 4,
    parameter int K_W = 8
) (
    input  logic           run,
    input  logic [K_W:0]   run_cnt,
    input  logic [K_W-1:0] k_reg,
    output logic [N-1:0]   feed_en
);

    always_comb begin
        feed_en = '0;
        for (int i = 0; i < N; i++) begin
            // Both bounds are evaluated in K_W+1 bits so i + k_reg cannot wrap.
            feed_en[i] = run
                      && (run_cnt >= (K_W+1)'(i))
                      && (run_cnt <  ({1'b0, k_reg} + (K_W+1)'(i)));
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for an NxN systolic array. Each accepted start pulse runs one
// sequence: CLEAR (accumulator clear) -> RUN (skewed operand feed) ->
// DRAIN (pipeline flush) -> DONE (one-cycle completion pulse) -> IDLE.
// A zero-length sequence skips RUN and DRAIN.
// Optional feature: define SYS_CTRL_ABORT_EN to add the abort input, which
// returns the sequencer to IDLE from CLEAR, RUN or DRAIN without a done pulse.
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      synchronous active-high reset
//   start    in  1      sequence request, sampled only in IDLE
//   k_len    in  K_W    operand stream length, latched on start
//   abort    in  1      (SYS_CTRL_ABORT_EN only) cancel running sequence
//   busy     out 1      high in every state except IDLE
//   clr_acc  out 1      accumulator clear pulse
//   feed_en  out N      per-row skewed operand valid
//   run_cnt  out K_W+1  cycle index inside RUN; row i reads operand run_cnt-i
//   done     out 1      completion pulse
// -----------------------------------------------------------------------------
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int K_W = DEF_K_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
`ifdef SYS_CTRL_ABORT_EN
    input  logic           abort,
`endif
    output logic           busy,
    output logic           clr_acc,
    output logic [N-1:0]   feed_en,
    output logic [K_W:0]   run_cnt,
    output logic           done
);

    localparam int DW = $clog2(N);

    state_t         state;
    logic [K_W-1:0] k_reg;
    logic [DW-1:0]  drain_cnt;
    logic [K_W:0]   last_cnt;
    logic           abort_hit;

    // Final RUN index: operand k_reg-1 reaches the last row N-1 cycles late.
    assign last_cnt = {1'b0, k_reg} + (K_W+1)'(N - 2);

`ifdef SYS_CTRL_ABORT_EN
    assign abort_hit = abort && ((state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN));
`else
    assign abort_hit = 1'b0;
`endif

    // k_reg is pure data: it is only meaningful after a start has latched it.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            k_reg <= k_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            clr_acc   <= 1'b0;
            done      <= 1'b0;
            run_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            clr_acc <= 1'b0;
            done    <= 1'b0;
            if (abort_hit) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                run_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_CLEAR;
                            busy    <= 1'b1;
                            clr_acc <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        run_cnt <= '0;
                        if (k_reg == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (run_cnt == last_cnt) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            run_cnt <= run_cnt + (K_W+1)'(1);
                        end
                    end
                    ST_DRAIN: begin
                        // run_cnt holds; DRAIN spans N-1 cycles.
                        if (drain_cnt == DW'(N - 2)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        run_cnt <= '0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

    sys_feed_skew #(
        .N   (N),
        .K_W (K_W)
    ) u_feed_skew (
        .run     (state == ST_RUN),
        .run_cnt (run_cnt),
        .k_reg   (k_reg),
        .feed_en (feed_en)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Self-checking bench for systolic_ctrl (N=4, K_W=8). A schedule-based
// reference model predicts every output from the cycle offset since the
// accepting start edge. Also exercises SYS_CTRL_ABORT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int N   = 4;
    localparam int K_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           abort;
    logic           busy;
    logic           clr_acc;
    logic [N-1:0]   feed_en;
    logic [K_W:0]   run_cnt;
    logic           done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: active flag, offset d since accept, latched length.
    bit m_act = 1'b0;
    int m_d   = 0;
    int m_k   = 0;

    typedef struct {
        int start;
        int k;
        int busy;
        int clr;
        int feed;
        int rc;
        int done;
    } vec_t;

    vec_t tv[16];

    systolic_ctrl #(.N(N), .K_W(K_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
`ifdef SYS_CTRL_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .clr_acc (clr_acc),
        .feed_en (feed_en),
        .run_cnt (run_cnt),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int m_last();
        return (m_k == 0) ? 1 : m_k + 2 * N - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (m_d == m_last()) m_act = 1'b0;
`ifdef SYS_CTRL_ABORT_EN
            else if (abort) m_act = 1'b0;
`endif
            else m_d++;
        end else if (start) begin
            m_act = 1'b1;
            m_d   = 0;
            m_k   = int'(k_len);
        end
    endtask

    task automatic check_model();
        int e_rc;
        int e_fe;
        e_rc = 0;
        e_fe = 0;
        if (m_act && m_k > 0 && m_d >= 1) begin
            if (m_d <= m_k + N - 1) begin
                e_rc = m_d - 1;
                for (int i = 0; i < N; i++)
                    if (e_rc >= i && e_rc < i + m_k) e_fe |= (1 << i);
            end else begin
                e_rc = m_k + N - 2;
            end
        end
        chk("model_busy", int'(busy), int'(m_act));
        chk("model_clr_acc", int'(clr_acc), int'(m_act && m_d == 0));
        chk("model_done", int'(done), int'(m_act && m_d == m_last()));
        chk("model_run_cnt", int'(run_cnt), e_rc);
        chk("model_feed_en", int'(feed_en), e_fe);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        int nd;
        int w0;
        int w3;
        int dpos;

        // Test 1 (k=4) then k=0, explicit expected values.
        tv[0]  = '{1, 4, 1, 1, 4'b0000, 0, 0};
        tv[1]  = '{0, 4, 1, 0, 4'b0001, 0, 0};
        tv[2]  = '{0, 4, 1, 0, 4'b0011, 1, 0};
        tv[3]  = '{0, 4, 1, 0, 4'b0111, 2, 0};
        tv[4]  = '{0, 4, 1, 0, 4'b1111, 3, 0};
        tv[5]  = '{0, 4, 1, 0, 4'b1110, 4, 0};
        tv[6]  = '{0, 4, 1, 0, 4'b1100, 5, 0};
        tv[7]  = '{0, 4, 1, 0, 4'b1000, 6, 0};
        tv[8]  = '{0, 4, 1, 0, 4'b0000, 6, 0};
        tv[9]  = '{0, 4, 1, 0, 4'b0000, 6, 0};
        tv[10] = '{0, 4, 1, 0, 4'b0000, 6, 0};
        tv[11] = '{0, 4, 1, 0, 4'b0000, 6, 1};
        tv[12] = '{0, 4, 0, 0, 4'b0000, 0, 0};
        tv[13] = '{1, 0, 1, 1, 4'b0000, 0, 0};
        tv[14] = '{0, 0, 1, 0, 4'b0000, 0, 1};
        tv[15] = '{0, 0, 0, 0, 4'b0000, 0, 0};

        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        abort = 1'b0;
        step();
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_feed_en", int'(feed_en), 0);
        chk("reset_run_cnt", int'(run_cnt), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        step();

        for (int r = 0; r < 16; r++) begin
            start = tv[r].start[0];
            k_len = K_W'(tv[r].k);
            step();
            chk($sformatf("tv%0d_busy", r), int'(busy), tv[r].busy);
            chk($sformatf("tv%0d_clr_acc", r), int'(clr_acc), tv[r].clr);
            chk($sformatf("tv%0d_feed_en", r), int'(feed_en), tv[r].feed);
            chk($sformatf("tv%0d_run_cnt", r), int'(run_cnt), tv[r].rc);
            chk($sformatf("tv%0d_done", r), int'(done), tv[r].done);
        end

        // start held high, k=2: accepts every 11 edges, done 9 edges after accept.
        start = 1'b1;
        k_len = K_W'(2);
        nd = 0;
        for (int i = 0; i < 33; i++) begin
            step();
            if (done) nd++;
        end
        chk("held_done_count", nd, 3);
        start = 1'b0;
        step();

        // Reset in RUN at run_cnt=3.
        start = 1'b1;
        k_len = K_W'(8);
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && !(busy && run_cnt == 3); i++) step();
        chk("rst_reach_rc3", int'(run_cnt), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_feed_en", int'(feed_en), 0);
        chk("rst_run_cnt", int'(run_cnt), 0);
        chk("rst_clr_acc", int'(clr_acc), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) nd++;
        end
        chk("rst_no_done", nd, 0);

        // k_len changed while busy.
        start = 1'b1;
        k_len = K_W'(4);
        step();
        start = 1'b0;
        k_len = K_W'(9);
        w0 = 0; w3 = 0; dpos = -1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (feed_en[0]) w0++;
            if (feed_en[N-1]) w3++;
            if (done) dpos = i;
        end
        chk("kchg_width_row0", w0, 4);
        chk("kchg_width_row3", w3, 4);
        chk("kchg_done_offset", dpos, 11);

`ifdef SYS_CTRL_ABORT_EN
        // Abort in DRAIN, then a normal sequence.
        start = 1'b1;
        k_len = K_W'(3);
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        start = 1'b1;
        k_len = K_W'(2);
        step();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) nd++;
        end
        chk("abort_then_run_done", nd, 1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom % 60) == 0;
            start = ($urandom % 3) == 0;
            k_len = K_W'($urandom_range(0, 12));
`ifdef SYS_CTRL_ABORT_EN
            abort = ($urandom % 25) == 0;
`endif
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("final_idle_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
